// File: rtl/imem_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit words and writes them
// to instruction memory from address 0, holding the CPU in reset until done.
module imem_loader #(
    parameter int WORDS = 64
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic [15:0] LEN,
    input  logic        BYTE_VALID,
    input  logic [7:0]  BYTE_DATA,
    output logic        BYTE_READY,
    output logic        WR_EN,
    output logic [31:0] WR_ADDR,
    output logic [31:0] WR_DATA,
    output logic        CPU_RST,
    output logic        BUSY,
    output logic        DONE
);

    localparam int CW = $clog2(WORDS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t          state_reg;
    logic [23:0]     shift_reg;
    logic [1:0]      byte_cnt_reg;
    logic [CW-1:0]   word_cnt_reg;
    logic [CW-1:0]   len_reg;
    logic            byte_ready_reg;
    logic            wr_en_reg;
    logic [31:0]     wr_addr_reg;
    logic [31:0]     wr_data_reg;
    logic            cpu_rst_reg;
    logic            busy_reg;
    logic            done_reg;

    logic [CW-1:0]   eff_len;
    logic [CW-1:0]   word_cnt_inc;

    // The clamp keeps every write address inside the memory.
    always_comb begin
        eff_len      = (LEN > 16'(WORDS)) ? CW'(WORDS) : CW'(LEN);
        word_cnt_inc = word_cnt_reg + CW'(1);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            byte_cnt_reg   <= '0;
            word_cnt_reg   <= '0;
            len_reg        <= '0;
            byte_ready_reg <= 1'b0;
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            cpu_rst_reg    <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            wr_en_reg <= 1'b0;
            case (state_reg)
                IDLE, FIN: begin
                    if (START) begin
                        len_reg      <= eff_len;
                        word_cnt_reg <= '0;
                        byte_cnt_reg <= '0;
                        wr_addr_reg  <= '0;
                        if (eff_len == '0) begin
                            state_reg      <= FIN;
                            byte_ready_reg <= 1'b0;
                            busy_reg       <= 1'b0;
                            done_reg       <= 1'b1;
                            cpu_rst_reg    <= 1'b0;
                        end else begin
                            state_reg      <= RECV;
                            byte_ready_reg <= 1'b1;
                            busy_reg       <= 1'b1;
                            done_reg       <= 1'b0;
                            cpu_rst_reg    <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (BYTE_VALID && byte_ready_reg) begin
                        shift_reg    <= {shift_reg[15:0], BYTE_DATA};
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        if (byte_cnt_reg == 2'd3) begin
                            state_reg      <= WRITE;
                            byte_ready_reg <= 1'b0;
                            wr_en_reg      <= 1'b1;
                            wr_data_reg    <= {shift_reg, BYTE_DATA};
                            wr_addr_reg    <= 32'(word_cnt_reg) << 2;
                        end
                    end
                end
                WRITE: begin
                    word_cnt_reg <= word_cnt_inc;
                    byte_cnt_reg <= '0;
                    if (word_cnt_inc == len_reg) begin
                        state_reg   <= FIN;
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        cpu_rst_reg <= 1'b0;
                    end else begin
                        state_reg      <= RECV;
                        byte_ready_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign BYTE_READY = byte_ready_reg;
    assign WR_EN      = wr_en_reg;
    assign WR_ADDR    = wr_addr_reg;
    assign WR_DATA    = wr_data_reg;
    assign CPU_RST    = cpu_rst_reg;
    assign BUSY       = busy_reg;
    assign DONE       = done_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a cycle table for the basic two-word load,
// then hand-written sequences for stalls, clamping, reset and restart.
module tb_imem_loader;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic [15:0] LEN = '0;
    logic        BYTE_VALID = 1'b0;
    logic [7:0]  BYTE_DATA = '0;
    logic        BYTE_READY;
    logic        WR_EN;
    logic [31:0] WR_ADDR;
    logic [31:0] WR_DATA;
    logic        CPU_RST;
    logic        BUSY;
    logic        DONE;

    imem_loader #(.WORDS(64)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .LEN(LEN),
        .BYTE_VALID(BYTE_VALID), .BYTE_DATA(BYTE_DATA), .BYTE_READY(BYTE_READY),
        .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .CPU_RST(CPU_RST), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Write monitor: one line per memory write.
    logic [31:0] wa [0:255];
    logic [31:0] wd [0:255];
    int          wr_count = 0;
    int          double_cnt = 0;
    logic        prev_wr = 1'b0;

    always @(negedge CLK) begin
        if (WR_EN) begin
            if (wr_count < 256) begin
                wa[wr_count] = WR_ADDR;
                wd[wr_count] = WR_DATA;
            end
            wr_count = wr_count + 1;
            $display("write %0d addr=%h data=%h", wr_count, WR_ADDR, WR_DATA);
            if (prev_wr) double_cnt = double_cnt + 1;
        end
        prev_wr = WR_EN;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic        start;
        logic [15:0] len;
        logic        valid;
        logic [7:0]  data;
        logic        ready;
        logic        wr_en;
        logic        cpu_rst;
        logic        busy;
        logic        done;
        logic [31:0] addr;
        logic [31:0] wdata;
    } vec_t;

    function automatic vec_t mk(input logic rst_n, input logic start, input logic [15:0] len,
                                input logic valid, input logic [7:0] data,
                                input logic ready, input logic wr_en, input logic cpu_rst,
                                input logic busy, input logic done,
                                input logic [31:0] addr, input logic [31:0] wdata);
        vec_t v;
        v.rst_n = rst_n; v.start = start; v.len = len; v.valid = valid; v.data = data;
        v.ready = ready; v.wr_en = wr_en; v.cpu_rst = cpu_rst; v.busy = busy;
        v.done = done; v.addr = addr; v.wdata = wdata;
        return v;
    endfunction

    logic [7:0] src [0:255];

    // Streams n bytes from src[first..]; valid optionally toggles every cycle.
    task automatic feed(input int first, input int n, input bit toggle, input string tag);
        int idx = 0;
        int cyc = 0;
        while (idx < n && cyc < 3000) begin
            @(negedge CLK);
            BYTE_VALID = toggle ? cyc[0] : 1'b1;
            BYTE_DATA  = src[first + idx];
            if (BYTE_VALID && BYTE_READY) idx++;
            cyc++;
        end
        @(posedge CLK);
        #1 BYTE_VALID = 1'b0;
        check({tag, "_bytes_accepted"}, 32'(idx), 32'(n));
    endtask

    task automatic start_load(input logic [15:0] len);
        @(negedge CLK);
        START = 1'b1;
        LEN   = len;
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!DONE && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_done"}, 32'(DONE), 32'd1);
        check({tag, "_cpu_rst"}, 32'(CPU_RST), 32'd0);
    endtask

    vec_t tbl [16];
    int   base;

    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 8'h00,  0, 0, 1, 0, 0, 32'h0, 32'h0);
        tbl[1]  = mk(1, 0, 0, 0, 8'h00,  0, 0, 1, 0, 0, 32'h0, 32'h0);
        tbl[2]  = mk(1, 0, 0, 0, 8'h00,  0, 0, 1, 0, 0, 32'h0, 32'h0);
        tbl[3]  = mk(1, 1, 2, 0, 8'h00,  0, 0, 1, 0, 0, 32'h0, 32'h0);
        tbl[4]  = mk(1, 0, 0, 1, 8'h20,  1, 0, 1, 1, 0, 32'h0, 32'h0);
        tbl[5]  = mk(1, 0, 0, 1, 8'h08,  1, 0, 1, 1, 0, 32'h0, 32'h0);
        tbl[6]  = mk(1, 0, 0, 1, 8'h00,  1, 0, 1, 1, 0, 32'h0, 32'h0);
        tbl[7]  = mk(1, 0, 0, 1, 8'h05,  1, 0, 1, 1, 0, 32'h0, 32'h0);
        tbl[8]  = mk(1, 0, 0, 1, 8'h8C,  0, 1, 1, 1, 0, 32'h0, 32'h20080005);
        tbl[9]  = mk(1, 0, 0, 1, 8'h8C,  1, 0, 1, 1, 0, 32'h0, 32'h0);
        tbl[10] = mk(1, 0, 0, 1, 8'h09,  1, 0, 1, 1, 0, 32'h0, 32'h0);
        tbl[11] = mk(1, 0, 0, 1, 8'h00,  1, 0, 1, 1, 0, 32'h0, 32'h0);
        tbl[12] = mk(1, 0, 0, 1, 8'h04,  1, 0, 1, 1, 0, 32'h0, 32'h0);
        tbl[13] = mk(1, 0, 0, 0, 8'h00,  0, 1, 1, 1, 0, 32'h4, 32'h8C090004);
        tbl[14] = mk(1, 0, 0, 0, 8'h00,  0, 0, 0, 0, 1, 32'h0, 32'h0);
        tbl[15] = mk(1, 0, 0, 0, 8'h00,  0, 0, 0, 0, 1, 32'h0, 32'h0);

        // Reset held for two edges, then the table takes over.
        repeat (2) @(posedge CLK);
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            check($sformatf("row%0d_ready", i), 32'(BYTE_READY), 32'(tbl[i].ready));
            check($sformatf("row%0d_wr_en", i), 32'(WR_EN), 32'(tbl[i].wr_en));
            check($sformatf("row%0d_cpu_rst", i), 32'(CPU_RST), 32'(tbl[i].cpu_rst));
            check($sformatf("row%0d_busy", i), 32'(BUSY), 32'(tbl[i].busy));
            check($sformatf("row%0d_done", i), 32'(DONE), 32'(tbl[i].done));
            if (tbl[i].wr_en || i == 0) begin
                check($sformatf("row%0d_addr", i), WR_ADDR, tbl[i].addr);
                check($sformatf("row%0d_wdata", i), WR_DATA, tbl[i].wdata);
            end
            RST_N      = tbl[i].rst_n;
            START      = tbl[i].start;
            LEN        = tbl[i].len;
            BYTE_VALID = tbl[i].valid;
            BYTE_DATA  = tbl[i].data;
        end
        START = 1'b0;
        BYTE_VALID = 1'b0;

        // Same two-word load with valid toggling, restarted from DONE.
        src[0] = 8'h20; src[1] = 8'h08; src[2] = 8'h00; src[3] = 8'h05;
        src[4] = 8'h8C; src[5] = 8'h09; src[6] = 8'h00; src[7] = 8'h04;
        base = wr_count;
        start_load(16'd2);
        feed(0, 8, 1'b1, "toggle");
        wait_done("toggle");
        check("toggle_writes", 32'(wr_count - base), 32'd2);
        check("toggle_addr0", wa[base], 32'h0);
        check("toggle_data0", wd[base], 32'h20080005);
        check("toggle_addr1", wa[base + 1], 32'h4);
        check("toggle_data1", wd[base + 1], 32'h8C090004);

        // Zero length from IDLE goes straight to DONE.
        @(negedge CLK);
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        base = wr_count;
        start_load(16'd0);
        @(negedge CLK);
        check("len0_done", 32'(DONE), 32'd1);
        check("len0_cpu_rst", 32'(CPU_RST), 32'd0);
        check("len0_busy", 32'(BUSY), 32'd0);
        check("len0_writes", 32'(wr_count - base), 32'd0);

        // Oversized length is clamped to the memory depth.
        for (int i = 0; i < 256; i++) src[i] = 8'(i);
        base = wr_count;
        start_load(16'd100);
        feed(0, 256, 1'b0, "clamp");
        wait_done("clamp");
        check("clamp_writes", 32'(wr_count - base), 32'd64);
        check("clamp_first_data", wd[base], 32'h00010203);
        check("clamp_last_addr", wa[base + 63], 32'h000000FC);
        check("clamp_last_data", wd[base + 63], 32'hFCFDFEFF);

        // Reset part-way through the first word discards it.
        src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; src[3] = 8'h44;
        src[4] = 8'hA1; src[5] = 8'hB2; src[6] = 8'hC3; src[7] = 8'hD4;
        base = wr_count;
        start_load(16'd3);
        feed(0, 2, 1'b0, "abort");
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        check("abort_ready", 32'(BYTE_READY), 32'd0);
        check("abort_cpu_rst", 32'(CPU_RST), 32'd1);
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_writes", 32'(wr_count - base), 32'd0);
        start_load(16'd1);
        feed(4, 4, 1'b0, "reload");
        wait_done("reload");
        check("reload_writes", 32'(wr_count - base), 32'd1);
        check("reload_addr", wa[base], 32'h0);
        check("reload_data", wd[base], 32'hA1B2C3D4);

        // Restart from DONE; a START during RECV must be ignored.
        src[0] = 8'hDE; src[1] = 8'hAD; src[2] = 8'hBE; src[3] = 8'hEF;
        base = wr_count;
        start_load(16'd1);
        @(negedge CLK);
        check("restart_cpu_rst", 32'(CPU_RST), 32'd1);
        check("restart_done", 32'(DONE), 32'd0);
        check("restart_ready", 32'(BYTE_READY), 32'd1);
        feed(0, 2, 1'b0, "restart_a");
        start_load(16'd5);
        feed(2, 2, 1'b0, "restart_b");
        wait_done("restart");
        check("restart_writes", 32'(wr_count - base), 32'd1);
        check("restart_addr", wa[base], 32'h0);
        check("restart_data", wd[base], 32'hDEADBEEF);

        repeat (3) @(negedge CLK);
        check("single_cycle_wr_en", 32'(double_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
